// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: status bit position,
// FSM state encoding and small helper functions.
package uart_tx_arbiter_pkg;

   localparam int ATX_FIFO_FULL_BIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = idx | (oh[i] ? 3'(i) : 3'd0);
      end
      return idx;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational rotate-priority picker: first valid index searching upward
// from last_grant+1 with wrap-around; one-hot result plus an any flag.
module uart_rr_picker
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] pick,
   output logic               any
);

   logic [IW-1:0] idx;

   // Walk offsets 1..NUM_REQ; the first valid hit masks all later ones.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx       = IW'((int'(last_grant) + k) % NUM_REQ);
         pick[idx] = pick[idx] | (req_valid[idx] & ~any);
         any       = any | req_valid[idx];
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding the UART ATX FIFO write port,
// with a stall watchdog that reclaims the grant from a stuck requester.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ATX_FULL_BIT   = ATX_FIFO_FULL_BIT
) (
   input  logic                 sysclk,
   input  logic                 sysreset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   input  logic [15:0]          atx_status_in,
   output logic [15:0]          data_out,
   output logic                 atx_reg_load,
   output logic                 abort_pulse,
   output logic [7:0]           abort_count
);

   localparam int IW   = $clog2(NUM_REQ);
   localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

   arb_state_t         state, state_nxt;
   logic [IW-1:0]      last_grant, last_grant_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [7:0]         data_reg, data_nxt;
   logic               load_nxt;
   logic               abort_nxt;
   logic [7:0]         abort_cnt_nxt;
   logic [WD_W-1:0]    wd_cnt, wd_nxt;
   logic               last_flag, last_flag_nxt;

   logic [NUM_REQ-1:0] pick;
   logic               pick_any;
   logic               full;
   logic               g_valid;
   logic               g_last;
   logic [7:0]         g_data;
   logic               status_unused;

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_picker (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .pick       (pick),
      .any        (pick_any)
   );

   assign full          = atx_status_in[ATX_FULL_BIT];
   assign status_unused = ^atx_status_in;
   assign g_valid       = |(req_valid & grant);
   assign g_last        = |(req_last & grant);
   assign req_ready     = ((state == ST_XFER) && !full) ? grant : '0;
   assign data_out      = {8'd0, data_reg};

   // Byte mux for the granted requester.
   always_comb begin
      g_data = 8'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         g_data = g_data | (req_data[8*i +: 8] & {8{grant[i]}});
      end
   end

   // Next-state, datapath and watchdog decisions.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      grant_nxt      = grant;
      data_nxt       = data_reg;
      load_nxt       = 1'b0;
      abort_nxt      = 1'b0;
      abort_cnt_nxt  = abort_count;
      wd_nxt         = wd_cnt;
      last_flag_nxt  = last_flag;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_nxt      = ST_XFER;
               grant_nxt      = pick;
               last_grant_nxt = IW'(onehot_idx(8'(pick)));
               wd_nxt         = '0;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_XFER: begin
            if (full) begin
               // A full FIFO is not the requester's fault: freeze the watchdog.
               wd_nxt = wd_cnt;
            end else if (g_valid) begin
               data_nxt      = g_data;
               load_nxt      = 1'b1;
               last_flag_nxt = g_last;
               wd_nxt        = '0;
               state_nxt     = ST_GAP;
            end else if (WD_EN && (wd_cnt == WD_MAX)) begin
               abort_nxt     = 1'b1;
               abort_cnt_nxt = sat_inc8(abort_count);
               grant_nxt     = '0;
               wd_nxt        = '0;
               state_nxt     = ST_IDLE;
            end else if (WD_EN) begin
               wd_nxt = wd_cnt + WD_W'(1);
            end else begin
               wd_nxt = wd_cnt;
            end
         end
         ST_GAP: begin
            // One dead cycle lets the full flag catch up with the last write.
            if (last_flag) begin
               grant_nxt = '0;
               state_nxt = ST_IDLE;
            end else begin
               wd_nxt    = '0;
               state_nxt = ST_XFER;
            end
         end
         default: begin
            grant_nxt = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge sysclk) begin
      if (!sysreset) begin
         state        <= ST_IDLE;
         last_grant   <= IW'(NUM_REQ - 1);
         grant        <= '0;
         data_reg     <= 8'd0;
         atx_reg_load <= 1'b0;
         abort_pulse  <= 1'b0;
         abort_count  <= 8'd0;
         wd_cnt       <= '0;
         last_flag    <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_grant   <= last_grant_nxt;
         grant        <= grant_nxt;
         data_reg     <= data_nxt;
         atx_reg_load <= load_nxt;
         abort_pulse  <= abort_nxt;
         abort_count  <= abort_cnt_nxt;
         wd_cnt       <= wd_nxt;
         last_flag    <= last_flag_nxt;
      end
   end

endmodule
